// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {instr, pc, inc_pc} between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to pass an entry straight through to decode when the queue is empty.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [29:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inc_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [29:0]              out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inc_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [29:0] NOP_INSTR = 30'h4;

  logic [29:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] inc_mem   [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          empty;
  logic          full;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          wr_en;
  logic          rd_en;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL_CNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = !flush && (!empty || bypass);
  assign pop       = out_valid && out_ready;
  assign in_ready  = !flush && (!full || pop);
  assign push      = in_valid && in_ready;

  // A bypassed entry is consumed in the same cycle and never touches storage.
  assign wr_en = push && !bypass;
  assign rd_en = pop && !bypass;

  assign count = cnt;

  always_comb begin
    out_instr  = NOP_INSTR;
    out_pc     = '0;
    out_inc_pc = '0;
    if (bypass) begin
      out_instr  = in_instr;
      out_pc     = in_pc;
      out_inc_pc = in_inc_pc;
    end else if (out_valid) begin
      out_instr  = instr_mem[rd_ptr];
      out_pc     = pc_mem[rd_ptr];
      out_inc_pc = inc_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)
        cnt <= cnt + 1'b1;
      else if (!wr_en && rd_en)
        cnt <= cnt - 1'b1;
    end
  end

  // Payload storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
      inc_mem[wr_ptr]   <= in_inc_pc;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the instruction fetch unit and the decode stage. Buffers up to DEPTH fetched instructions together with their PC and incremented PC, decouples fetch-bus latency from decode stalls, and is emptied in one cycle on a taken jump or branch. Decode sees a valid/ready stream and receives a canonical NOP whenever the queue has nothing to present.

## Interface
- XLEN, 32: PC width.
- DEPTH, 4: number of entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all entries (taken jump/branch); sampled on clk.
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue accepts an entry this cycle.
- in_instr  in  30  instruction bits [31:2], already decompressed.
- in_pc  in  XLEN  address of in_instr.
- in_inc_pc  in  XLEN  address of the following instruction.
- out_valid  out  1  entry presented to decode.
- out_ready  in  1  decode consumes the presented entry.
- out_instr  out  30  head instruction bits [31:2]; 30'h4 when out_valid=0.
- out_pc  out  XLEN  head PC; 0 when out_valid=0.
- out_inc_pc  out  XLEN  head incremented PC; 0 when out_valid=0.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Circular buffer of DEPTH entries {instr, pc, inc_pc}; read pointer, write pointer, count.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Push: in_valid && in_ready writes the entry at the write pointer and advances it.
- Pop: out_valid && out_ready advances the read pointer.
- in_ready = (count != DEPTH) || pop this cycle. A push into a full queue is accepted when a pop occurs in the same cycle.
- out_valid = (count != 0), or the bypass condition (see Configuration).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Flush has priority over push and pop. On flush the pointers and count go to 0 at the next edge, and the entry presented on in_* that cycle is dropped.
- During the flush cycle, in_ready and out_valid are both forced to 0, so no handshake completes in that cycle.
- Entry payloads are not cleared on flush or reset. Only the pointers and count are.
- When out_valid=0, the outputs are forced to out_instr=30'h4 (addi x0,x0,0) and out_pc=out_inc_pc=0.

## Timing
- Reset (rst_n low, asynchronous): pointers=0, count=0, out_valid=0, out_instr=30'h4, out_pc=0, out_inc_pc=0, in_ready=1.
- Reset deassertion mid-operation leaves the queue empty. Entries held before reset are lost.
- Latency without bypass: an entry pushed at edge N is presented on out_* after edge N, and can be popped at edge N+1.
- Throughput: one push and one pop per cycle sustained, at any occupancy.
- out_* are driven from registered storage indexed by the read pointer. There is no combinational path from in_* to out_* unless bypass is enabled.
- in_ready depends combinationally on out_ready (full case) and on flush.
- Handshake rules:
  - The producer must hold in_* stable while in_valid && !in_ready.
  - The queue holds out_* stable while out_valid && !out_ready.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0, in_valid=1, out_ready=1 and flush=0, the in_* entry is presented combinationally on out_* with out_valid=1.
  - It is consumed in the same cycle and is not written into storage. Latency is 0 cycles.
- FETCH_QUEUE_BYPASS_EN undefined:
  - No bypass path exists. An empty queue always adds one cycle of latency.

## Test plan
- Reset: hold rst_n=0 mid-stream with count=3 -> count=0, out_valid=0, out_instr=30'h4, in_ready=1 immediately, without waiting for a clock edge.
- Fill and drain, DEPTH=4, out_ready=0:
  - Push pc 0x100, 0x104, 0x108, 0x10C -> count=4, in_ready=0.
  - Then out_ready=1 -> pops in order 0x100..0x10C, wrap-around occurs, and count returns to 0.
- Full with simultaneous push and pop: count=4, in_valid=1, out_ready=1 -> push accepted, count stays 4, the head advances by one.
- Flush priority: count=2, assert flush with in_valid=1 and out_ready=1 -> no handshake completes, count=0 next cycle, and the next pushed pc 0x200 is the first entry popped.
- Stall hold: out_ready=0 for 5 cycles with count=1 -> out_pc and out_instr stay constant and count stays 1.
- Latency check with an empty queue, pushing pc 0x40:
  - With FETCH_QUEUE_BYPASS_EN and out_ready=1 -> out_pc=0x40 in the same cycle, and count stays 0.
  - Without the macro -> out_pc=0x40 one cycle later.
